led_rate_sequencer: RTL and testbench

LED_RATE_SEQUENCER -- requirements
Module: led_rate_sequencer

---
 rtl/led_rate_sequencer.sv | 141 ++++++++++++++
 tb/tb_led_rate_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/led_rate_sequencer.sv
// LED blink-rate sequencer: debounced mode/step switches drive an IDLE/AUTO/MANUAL
// FSM that cycles a 2-bit rate select, either on a dwell timer or on manual steps.
module led_rate_sequencer #(
    parameter int unsigned c_DWELL_CNT    = 25000000,
    parameter int unsigned c_DEBOUNCE_CNT = 250000
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_enable,
    input  logic       i_switch_1,
    input  logic       i_switch_2,
    output logic [1:0] o_rate_sel,
    output logic       o_step,
    output logic       o_active
);

    localparam int unsigned DB_W = $clog2(c_DEBOUNCE_CNT) + 1;
    localparam int unsigned DW_W = $clog2(c_DWELL_CNT) + 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(c_DEBOUNCE_CNT - 1);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(c_DWELL_CNT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_AUTO   = 2'd1;
    localparam logic [1:0] ST_MANUAL = 2'd2;

    // bit 0 = mode switch, bit 1 = step switch
    logic [1:0]      sw_raw;
    logic [1:0]      meta_q, sync_q;
    logic [1:0]      deb_q, deb_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    logic [1:0]      state_q, state_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [1:0]      rate_q, rate_d;
    logic            step_q, step_d;
    logic            active_q, active_d;

    logic            sw1_lvl;
    logic            sw2_rise;
    logic            advance;

    assign sw_raw = {i_switch_2, i_switch_1};

    always_comb begin
        deb_d = deb_q;
        for (int unsigned i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // The FSM acts on the debouncer's next level, so a switch change takes
    // effect exactly 2 + c_DEBOUNCE_CNT edges after it is sampled.
    assign sw1_lvl  = deb_d[0];
    assign sw2_rise = deb_d[1] & ~deb_q[1];

    always_comb begin
        state_d = state_q;
        dwell_d = '0;
        rate_d  = rate_q;
        step_d  = 1'b0;
        advance = 1'b0;

        if (!i_enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = sw1_lvl ? ST_MANUAL : ST_AUTO;
                end
                ST_AUTO: begin
                    if (sw1_lvl) begin
                        state_d = ST_MANUAL;
                    end else if (dwell_q == DW_LAST) begin
                        advance = 1'b1;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                ST_MANUAL: begin
                    if (!sw1_lvl) begin
                        state_d = ST_AUTO;
                    end else if (sw2_rise) begin
                        advance = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (advance) begin
            rate_d = rate_q + 1'b1;
            step_d = 1'b1;
        end

        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            meta_q   <= '0;
            sync_q   <= '0;
            deb_q    <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
            state_q  <= ST_IDLE;
            dwell_q  <= '0;
            rate_q   <= '0;
            step_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            meta_q   <= sw_raw;
            sync_q   <= meta_q;
            deb_q    <= deb_d;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            rate_q   <= rate_d;
            step_q   <= step_d;
            active_q <= active_d;
        end
    end

    assign o_rate_sel = rate_q;
    assign o_step     = step_q;
    assign o_active   = active_q;

endmodule

// File: tb/tb_led_rate_sequencer.sv
// Directed bench for led_rate_sequencer with dwell = 8 and debounce = 4 cycles;
// edges are counted by hand and outputs sampled 1 time unit after each rising edge.
module tb_led_rate_sequencer;

    localparam logic [1:0] ST_AUTO   = 2'd1;
    localparam logic [1:0] ST_MANUAL = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       sw1;
    logic       sw2;
    logic [1:0] rate_sel;
    logic       step;
    logic       active;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    led_rate_sequencer #(
        .c_DWELL_CNT    (8),
        .c_DEBOUNCE_CNT (4)
    ) dut (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_enable   (en),
        .i_switch_1 (sw1),
        .i_switch_2 (sw2),
        .o_rate_sel (rate_sel),
        .o_step     (step),
        .o_active   (active)
    );

    always #5 clk = ~clk;

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        sw1   = 1'b0;
        sw2   = 1'b0;

        // Reset state
        tick(3);
        chk("rst_rate",   32'(rate_sel), 32'd0);
        chk("rst_step",   32'(step),     32'd0);
        chk("rst_active", 32'(active),   32'd0);

        // AUTO wrap: enable applied while in reset, release between edges
        en = 1'b1;
        #2 rst_n = 1'b1;
        tick(1);
        chk("auto_active_e1", 32'(active),   32'd1);
        chk("auto_rate_e1",   32'(rate_sel), 32'd0);
        tick(7);
        chk("auto_rate_e8",   32'(rate_sel), 32'd0);
        chk("auto_step_e8",   32'(step),     32'd0);
        tick(1);
        chk("auto_rate_01",   32'(rate_sel), 32'd1);
        chk("auto_step_01",   32'(step),     32'd1);
        tick(1);
        chk("auto_step_clr",  32'(step),     32'd0);
        tick(7);
        chk("auto_rate_10",   32'(rate_sel), 32'd2);
        chk("auto_step_10",   32'(step),     32'd1);
        tick(8);
        chk("auto_rate_11",   32'(rate_sel), 32'd3);
        chk("auto_step_11",   32'(step),     32'd1);
        tick(8);
        chk("auto_rate_wrap", 32'(rate_sel), 32'd0);
        chk("auto_step_wrap", 32'(step),     32'd1);

        // Mode switch raised at dwell count 5; one more AUTO step lands first
        tick(5);
        sw1 = 1'b1;
        tick(3);
        chk("mode_last_step", 32'(rate_sel), 32'd1);
        chk("mode_last_pls",  32'(step),     32'd1);
        tick(2);
        chk("mode_still_auto", 32'(dut.state_q), 32'(ST_AUTO));
        tick(1);
        chk("mode_manual",     32'(dut.state_q), 32'(ST_MANUAL));
        chk("mode_active",     32'(active),      32'd1);
        tick(20);
        chk("manual_frozen",   32'(rate_sel),    32'd1);
        chk("manual_nostep",   32'(step),        32'd0);

        // Step switch: 3-cycle glitch rejected
        sw2 = 1'b1;
        tick(3);
        sw2 = 1'b0;
        tick(10);
        chk("glitch_rate", 32'(rate_sel), 32'd1);

        // Step switch held 10 cycles: one advance, 6 edges after the rise
        sw2 = 1'b1;
        tick(5);
        chk("db_rate_e5",  32'(rate_sel), 32'd1);
        chk("db_step_e5",  32'(step),     32'd0);
        tick(1);
        chk("db_rate_e6",  32'(rate_sel), 32'd2);
        chk("db_step_e6",  32'(step),     32'd1);
        tick(1);
        chk("db_step_e7",  32'(step),     32'd0);
        tick(3);
        sw2 = 1'b0;
        tick(12);
        chk("fall_rate",   32'(rate_sel), 32'd2);
        chk("fall_step",   32'(step),     32'd0);

        // Back to AUTO; fresh dwell, then enable falls on the terminal cycle
        sw1 = 1'b0;
        tick(6);
        chk("back_auto",      32'(dut.state_q), 32'(ST_AUTO));
        chk("back_auto_rate", 32'(rate_sel),    32'd2);
        tick(7);
        chk("dwell_e7_rate",  32'(rate_sel),    32'd2);
        chk("dwell_e7_step",  32'(step),        32'd0);
        en = 1'b0;
        tick(1);
        chk("dis_step",   32'(step),     32'd0);
        chk("dis_rate",   32'(rate_sel), 32'd2);
        chk("dis_active", 32'(active),   32'd0);
        tick(4);
        chk("idle_rate",   32'(rate_sel), 32'd2);
        chk("idle_active", 32'(active),   32'd0);

        // Re-enable: resume from 10, next step to 11 after a full dwell
        en = 1'b1;
        tick(1);
        chk("reen_active", 32'(active),   32'd1);
        tick(7);
        chk("reen_rate_e8", 32'(rate_sel), 32'd2);
        tick(1);
        chk("reen_rate_11", 32'(rate_sel), 32'd3);
        chk("reen_step_11", 32'(step),     32'd1);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rate",   32'(rate_sel), 32'd0);
        chk("arst_step",   32'(step),     32'd0);
        chk("arst_active", 32'(active),   32'd0);
        tick(2);
        chk("arst_hold_active", 32'(active), 32'd0);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_active", 32'(active),   32'd1);
        chk("post_rst_rate",   32'(rate_sel), 32'd0);
        tick(8);
        chk("post_rst_step",   32'(rate_sel), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
